// File: rtl/prio_encoder_rr_if.sv
// Request/handshake bundle for prio_encoder_rr: the request bank on one side,
// the registered encoded index with its valid/ready handshake on the other.
interface prio_encoder_rr_if #(
   parameter int N = 16
);
   localparam int W = $clog2(N);

   logic         en;
   logic         rr_mode;
   logic [N-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;

   modport master (
      input  en,
      input  rr_mode,
      input  req,
      input  out_ready,
      output out_valid,
      output out_idx,
      output out_onehot
   );

   modport slave (
      output en,
      output rr_mode,
      output req,
      output out_ready,
      input  out_valid,
      input  out_idx,
      input  out_onehot
   );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin selection
// and a single-entry valid/ready output register.
module prio_encoder_rr #(
   parameter int N = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   prio_encoder_rr_if.master     bus_io
);
   localparam int W = $clog2(N);

   logic [W-1:0] ptr_q,    ptr_d;
   logic         vld_q,    vld_d;
   logic [W-1:0] idx_q,    idx_d;
   logic [N-1:0] onehot_q, onehot_d;

   logic         load;
   logic         accept;
   logic [W-1:0] sel;

   function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] r);
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) begin
         if (r[i]) s = W'(i);
      end
      return s;
   endfunction

   // Circular search starting at p; p is always < N so one subtraction wraps.
   function automatic logic [W-1:0] sel_rr(input logic [N-1:0] r, input logic [W-1:0] p);
      logic [W-1:0] s;
      logic         found;
      int           j;
      s     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(p) + k;
         if (j >= N) j = j - N;
         if (!found && r[j]) begin
            s     = W'(j);
            found = 1'b1;
         end
      end
      return s;
   endfunction

   assign accept = vld_q & bus_io.out_ready;
   assign load   = bus_io.en & (|bus_io.req) & (~vld_q | bus_io.out_ready);
   assign sel    = bus_io.rr_mode ? sel_rr(bus_io.req, ptr_q) : sel_fixed(bus_io.req);

   always_comb begin
      ptr_d    = ptr_q;
      vld_d    = vld_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      if (load) begin
         vld_d    = 1'b1;
         idx_d    = sel;
         onehot_d = {{(N-1){1'b0}}, 1'b1} << sel;
         if (bus_io.rr_mode) begin
            ptr_d = (sel == W'(N-1)) ? '0 : sel + 1'b1;
         end
      end else if (accept) begin
         // out_idx deliberately keeps its last value once drained
         vld_d    = 1'b0;
         onehot_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= '0;
         vld_q    <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         vld_q    <= vld_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
      end
   end

   assign bus_io.out_valid  = vld_q;
   assign bus_io.out_idx    = idx_q;
   assign bus_io.out_onehot = onehot_q;
endmodule
